// File: rtl/pong_pkg.sv
// Shared Pong display-path types: full-screen image select, game-flow states
// and the mapping from game state to the screen that state wants shown.
package pong_pkg;

   typedef enum logic [1:0] {
      SCR_TITLE = 2'd0,
      SCR_PLAY  = 2'd1,
      SCR_P1WIN = 2'd2,
      SCR_P2WIN = 2'd3
   } screen_e;

   typedef enum logic [2:0] {
      TITLE,
      SERVE,
      PLAY,
      P1_WIN,
      P2_WIN
   } game_state_e;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   function automatic screen_e pending_screen(game_state_e st);
      case (st)
         TITLE:   return SCR_TITLE;
         P1_WIN:  return SCR_P1WIN;
         P2_WIN:  return SCR_P2WIN;
         default: return SCR_PLAY;
      endcase
   endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Game-flow bus between the VGA/game logic (master) and the screen sequencer
// (slave): raster position, player events in, screen select and scores out.
interface screen_sequencer_if #(
   parameter int SCORE_W = 4
);
   logic [9:0]          DrawX;
   logic [9:0]          DrawY;
   logic                start;
   logic                p1_point;
   logic                p2_point;
   pong_pkg::screen_e   screen_sel;
   logic                game_active;
   logic [SCORE_W-1:0]  p1_score;
   logic [SCORE_W-1:0]  p2_score;
   logic                frame_tick;

   modport master (
      output DrawX, DrawY, start, p1_point, p2_point,
      input  screen_sel, game_active, p1_score, p2_score, frame_tick
   );

   modport slave (
      input  DrawX, DrawY, start, p1_point, p2_point,
      output screen_sel, game_active, p1_score, p2_score, frame_tick
   );
endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle frame pulse, registered one clock after the raster origin (0,0)
// is sampled; shared with the ball and paddle logic.
module frame_tick_gen (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic [9:0] draw_x_i,
   input  logic [9:0] draw_y_i,
   output logic       frame_tick_o
);

   logic tick_q;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= (draw_x_i == 10'd0) && (draw_y_i == 10'd0);
      end
   end

   assign frame_tick_o = tick_q;

endmodule

// File: rtl/screen_sequencer.sv
// Pong game-flow controller: tracks scores, sequences title/serve/play/win
// screens and switches the image source only on frame boundaries.
//
//   state  | meaning
//   TITLE  | title image, waiting for a start press
//   SERVE  | playfield shown, ball held for SERVE_FRAMES frames
//   PLAY   | ball and paddles live, waiting for a point
//   P1_WIN | player 1 win image for WIN_FRAMES frames
//   P2_WIN | player 2 win image for WIN_FRAMES frames
module screen_sequencer
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_FRAMES   = 180,
   parameter int SCORE_W      = 4
) (
   input logic               vga_clk,
   input logic               reset_n,
   screen_sequencer_if.slave bus
);

   localparam int MAX_FRAMES = (SERVE_FRAMES > WIN_FRAMES) ? SERVE_FRAMES : WIN_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
   localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]   WIN_CNT   = CNT_W'(WIN_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_PTS   = SCORE_W'(WIN_SCORE);

   game_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [SCORE_W-1:0] p1_q, p1_d, p1_inc;
   logic [SCORE_W-1:0] p2_q, p2_d, p2_inc;
   screen_e            screen_q, screen_d;
   logic               active_q;
   logic               start_q;
   logic               start_rise;
   logic               frame_tick;

   frame_tick_gen u_frame_tick_gen (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .draw_x_i     (bus.DrawX),
      .draw_y_i     (bus.DrawY),
      .frame_tick_o (frame_tick)
   );

   assign start_rise = bus.start & ~start_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      cnt_inc = cnt_q + 1'b1;
      p1_inc  = p1_q + 1'b1;
      p2_inc  = p2_q + 1'b1;
      unique case (state_q)
         TITLE: begin
            if (start_rise) begin
               state_d = SERVE;
               p1_d    = '0;
               p2_d    = '0;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (cnt_inc == SERVE_CNT) state_d = PLAY;
               else                      cnt_d   = cnt_inc;
            end
         end
         PLAY: begin
            // player 1 wins a same-cycle tie; the p2 pulse is simply dropped
            if (bus.p1_point) begin
               p1_d    = p1_inc;
               state_d = (p1_inc == WIN_PTS) ? P1_WIN : SERVE;
            end else if (bus.p2_point) begin
               p2_d    = p2_inc;
               state_d = (p2_inc == WIN_PTS) ? P2_WIN : SERVE;
            end
         end
         P1_WIN, P2_WIN: begin
            if (frame_tick) begin
               if (cnt_inc == WIN_CNT) state_d = TITLE;
               else                    cnt_d   = cnt_inc;
            end
         end
         default: state_d = TITLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
      // the old state's screen is latched on a tick, so a same-cycle change waits a frame
      screen_d = frame_tick ? pending_screen(state_q) : screen_q;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= TITLE;
         cnt_q    <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         screen_q <= SCR_TITLE;
         active_q <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         screen_q <= screen_d;
         active_q <= (state_d == PLAY);
         start_q  <= bus.start;
      end
   end

   assign bus.screen_sel  = screen_q;
   assign bus.game_active = active_q;
   assign bus.p1_score    = p1_q;
   assign bus.p2_score    = p2_q;
   assign bus.frame_tick  = frame_tick;

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Game-flow controller for the Pong display path.
- Tracks scores and sequences TITLE → SERVE → PLAY → P1/P2 win screen → TITLE.
- Drives screen_sel, which picks the full-screen image source (title image, playfield renderer, P1-wins image, P2-wins image) feeding the VGA colour registers.
- Screen changes are frame-aligned so no image source is ever switched mid-frame.

Parameters:
- WIN_SCORE, 7: points needed to win; the score reaching this value ends the game.
- SERVE_FRAMES, 60: frames of SERVE hold before ball release (1 s at 60 Hz).
- WIN_FRAMES, 180: frames the win screen is shown before returning to TITLE.
- SCORE_W, 4: score counter width; must satisfy WIN_SCORE < 2^SCORE_W.

Ports:
- vga_clk input 1: pixel clock; the only clock.
- reset_n input 1: asynchronous, active-low reset.
- DrawX input 10: current pixel column from the VGA controller.
- DrawY input 10: current pixel row from the VGA controller.
- start input 1: start button level, already synchronised to vga_clk.
- p1_point input 1: one-cycle pulse, player 1 scored.
- p2_point input 1: one-cycle pulse, player 2 scored.
- screen_sel output 2: registered screen_e, the image source select.
- game_active output 1: high only in PLAY; enables ball and paddle motion.
- p1_score output SCORE_W: player 1 score.
- p2_score output SCORE_W: player 2 score.
- frame_tick output 1: one-cycle pulse per frame.

Behaviour:
- Reset values while reset_n is low: state=TITLE, screen_sel=SCR_TITLE, game_active=0, scores=0, frame_tick=0, frame counter=0, start history=0.
- frame_tick:
  - Registered; high the cycle after DrawX==0 and DrawY==0 is sampled.
  - Fires once per frame, even though (0,0) is held for only one pixel clock.
- start is edge-detected: start_rise = start & ~start_q. Holding start does not retrigger.
- TITLE:
  - start_rise → SERVE; clear both scores in the same cycle.
  - Point pulses are ignored.
- SERVE:
  - Frame counter is cleared on entry and increments on each frame_tick.
  - When the count reaches SERVE_FRAMES → PLAY, with the counter cleared.
  - Point pulses are ignored; game_active=0.
- PLAY (game_active=1):
  - p1_point increments p1_score.
  - If the new value equals WIN_SCORE → P1_WIN; otherwise → SERVE.
  - p2_point is handled symmetrically, going to P2_WIN on a win.
  - If p1_point and p2_point arrive in the same cycle, p1 takes priority and p2_point is dropped.
  - start is ignored.
- P1_WIN / P2_WIN:
  - Frame counter counts frame_tick; at WIN_FRAMES → TITLE.
  - Scores are held, so the final score stays visible.
  - start and point pulses are ignored.
- game_active is a registered decode of the state: it rises the cycle after entering PLAY and falls the cycle after leaving PLAY.
- screen_sel:
  - pending screen: TITLE→SCR_TITLE, SERVE/PLAY→SCR_PLAY, P1_WIN→SCR_P1WIN, P2_WIN→SCR_P2WIN.
  - screen_sel loads the pending screen only on frame_tick cycles and holds between ticks.
  - Worst-case display latency is one frame.
- Frame counter:
  - Width is $clog2(max(SERVE_FRAMES, WIN_FRAMES)+1).
  - Cleared on every state change; it never wraps because the exit fires on equality.
- If a state transition and frame_tick occur in the same cycle, screen_sel takes the pending screen of the old state. The new state's screen appears on the next tick.
- Reset asserted mid-game returns all state to reset values immediately (asynchronous). Scores do not survive reset.
- Scores saturate by construction, since the game ends at WIN_SCORE.

Decomposition:
- Shared package pong_pkg:
  - typedef enum logic [1:0] screen_e {SCR_TITLE=0, SCR_PLAY=1, SCR_P1WIN=2, SCR_P2WIN=3}. The image mux in the top level uses the same type.
  - typedef enum game_state_e {TITLE, SERVE, PLAY, P1_WIN, P2_WIN}.
  - Constants H_ACTIVE=640, V_ACTIVE=480.
- One sub-module, frame_tick_gen: takes vga_clk, reset_n, DrawX, DrawY and produces the frame_tick pulse. It is reusable by the ball and paddle logic.

Test Plan:
- Reset: hold reset_n=0 for 10 cycles, release → screen_sel=SCR_TITLE, game_active=0, scores=0. No frame_tick until (0,0) is driven.
- Start and serve:
  - Pulse start in TITLE; run VGA timing with SERVE_FRAMES=2.
  - Required: screen_sel=SCR_PLAY after the next frame_tick.
  - Required: game_active=1 exactly the cycle after the 2nd subsequent frame_tick.
- Point and re-serve: in PLAY, pulse p2_point → p2_score=1, game_active=0 next cycle, PLAY re-entered after SERVE_FRAMES ticks.
- Win path:
  - With WIN_SCORE=3 and WIN_FRAMES=4, deliver 3 p1_point pulses (one per PLAY entry).
  - Required: screen_sel=SCR_P1WIN at the next frame_tick, p1_score holds 3, state returns to TITLE after 4 ticks.
  - Required: start pressed during the win screen has no effect.
- Simultaneous points: in PLAY, drive p1_point=p2_point=1 in one cycle → p1_score+1, p2_score unchanged.
- Mid-frame safety and reset:
  - Cause a win with DrawY=200; screen_sel must not change until (0,0) is reached.
  - Assert reset_n low mid-SERVE → outputs return to reset values without waiting for a clock edge.
